// File: rtl/altera_tse_gxb_rxsync_multilane.sv
// altera_tse_gxb_rxsync_multilane
// Multi-lane RX sync aligner between the GXB transceiver RX outputs and the
// 1000BASE-X PCS receive machine. Per lane it qualifies word-aligner sync,
// delays the decoder status by PIPE_DEPTH stages, squelches symbols that
// were not captured under lock, counts sync losses, and derives a
// hysteretic carrier-detect.
//
// Ports
//   clk, reset                 recovered RX clock, synchronous active-high reset
//   alt_*                      raw per-lane transceiver outputs (byte lane n = [8n+7:8n])
//   cnt_clr                    clears every lane's sync-loss counter
//   altpcs_*                   aligned, squelched per-lane outputs
//   altpcs_carrierdetect       1 = carrier present
//   altpcs_all_locked          registered AND of altpcs_sync
//   sync_loss_cnt              8-bit saturating sync-loss count per lane
//
// Sync FSM states
//   state     | meaning
//   ST_LOST   | no alignment; waiting for alt_sync
//   ST_QUAL   | alt_sync seen for qcnt consecutive cycles
//   ST_LOCKED | qualified lock; symbols pass unsquelched
module altera_tse_gxb_rxsync_multilane #(
  parameter int LANES      = 1,
  parameter int PIPE_DEPTH = 2,
  parameter int SYNC_QUAL  = 4,
  parameter int CD_HOLD    = 8,
  parameter int CD_RECOVER = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8*LANES-1:0]   alt_dataout,
  input  logic [LANES-1:0]     alt_sync,
  input  logic [LANES-1:0]     alt_disperr,
  input  logic [LANES-1:0]     alt_ctrldetect,
  input  logic [LANES-1:0]     alt_errdetect,
  input  logic [LANES-1:0]     alt_rmfifodatadeleted,
  input  logic [LANES-1:0]     alt_rmfifodatainserted,
  input  logic [LANES-1:0]     alt_runlengthviolation,
  input  logic                 cnt_clr,
  output logic [8*LANES-1:0]   altpcs_dataout,
  output logic [LANES-1:0]     altpcs_sync,
  output logic [LANES-1:0]     altpcs_disperr,
  output logic [LANES-1:0]     altpcs_ctrldetect,
  output logic [LANES-1:0]     altpcs_errdetect,
  output logic [LANES-1:0]     altpcs_rmfifodatadeleted,
  output logic [LANES-1:0]     altpcs_rmfifodatainserted,
  output logic [LANES-1:0]     altpcs_carrierdetect,
  output logic                 altpcs_all_locked,
  output logic [8*LANES-1:0]   sync_loss_cnt
);

  localparam logic [7:0] SYNC_QUAL_C  = 8'(SYNC_QUAL);
  localparam logic [7:0] CD_HOLD_C    = 8'(CD_HOLD);
  localparam logic [7:0] CD_RECOVER_C = 8'(CD_RECOVER);

  // Pipeline word: {lock, rm_ins, rm_del, ctrl, err, disp, data[7:0]}
  localparam int         PW      = 14;
  localparam int         B_DISP  = 8;
  localparam int         B_ERR   = 9;
  localparam int         B_CTRL  = 10;
  localparam int         B_RMDEL = 11;
  localparam int         B_RMINS = 12;
  localparam int         B_LOCK  = 13;
  // Squelch: data 0, disperr 1, errdetect 1, everything else 0, lock 0.
  localparam logic [PW-1:0] SQUELCH = 14'h0300;

  typedef enum logic [1:0] {ST_LOST, ST_QUAL, ST_LOCKED} state_t;

  logic [LANES-1:0] lock_final;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    state_t                     state;
    logic [7:0]                 qcnt;
    logic                       lock_nxt;
    logic                       loss;
    logic [PIPE_DEPTH-1:0][PW-1:0] pipe;
    logic [PW-1:0]              last;
    logic [PW-1:0]              out_word;
    logic                       stage1_invalid;
    logic [7:0]                 icnt;
    logic [7:0]                 vcnt;
    logic                       cd;
    logic [7:0]                 loss_cnt;

    // The lock bit travels with the symbol of the cycle in which the FSM
    // decides to enter (or stay in) LOCKED, so it mirrors the next state.
    always_comb begin
      lock_nxt = 1'b0;
      if (alt_sync[n]) begin
        unique case (state)
          ST_LOST:   lock_nxt = (SYNC_QUAL_C == 8'd1);
          ST_QUAL:   lock_nxt = (qcnt + 8'd1 == SYNC_QUAL_C);
          ST_LOCKED: lock_nxt = 1'b1;
          default:   lock_nxt = 1'b0;
        endcase
      end
    end

    assign loss = (state == ST_LOCKED) && !alt_sync[n];

    always_ff @(posedge clk) begin
      if (reset) begin
        state <= ST_LOST;
        qcnt  <= 8'd0;
      end else begin
        unique case (state)
          ST_LOST: begin
            if (alt_sync[n]) begin
              if (SYNC_QUAL_C == 8'd1) begin
                state <= ST_LOCKED;
                qcnt  <= 8'd0;
              end else begin
                state <= ST_QUAL;
                qcnt  <= 8'd1;
              end
            end
          end
          ST_QUAL: begin
            if (!alt_sync[n]) begin
              state <= ST_LOST;
              qcnt  <= 8'd0;
            end else if (qcnt + 8'd1 == SYNC_QUAL_C) begin
              state <= ST_LOCKED;
              qcnt  <= 8'd0;
            end else begin
              qcnt <= qcnt + 8'd1;
            end
          end
          ST_LOCKED: begin
            if (!alt_sync[n]) begin
              state <= ST_LOST;
              qcnt  <= 8'd0;
            end
          end
          default: begin
            state <= ST_LOST;
            qcnt  <= 8'd0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= SQUELCH;
      end else begin
        pipe[0] <= {lock_nxt, alt_rmfifodatainserted[n], alt_rmfifodatadeleted[n],
                    alt_ctrldetect[n], alt_errdetect[n], alt_disperr[n],
                    alt_dataout[8*n +: 8]};
        for (int i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign last     = pipe[PIPE_DEPTH-1];
    assign out_word = last[B_LOCK] ? last : SQUELCH;

    assign altpcs_dataout[8*n +: 8]     = out_word[7:0];
    assign altpcs_disperr[n]            = out_word[B_DISP];
    assign altpcs_errdetect[n]          = out_word[B_ERR];
    assign altpcs_ctrldetect[n]         = out_word[B_CTRL];
    assign altpcs_rmfifodatadeleted[n]  = out_word[B_RMDEL];
    assign altpcs_rmfifodatainserted[n] = out_word[B_RMINS];
    assign altpcs_sync[n]               = out_word[B_LOCK];
    assign lock_final[n]                = out_word[B_LOCK];

    // Carrier detect works on stage 1 so it reacts ahead of the data output.
    assign stage1_invalid = !pipe[0][B_LOCK] | (pipe[0][B_ERR] & pipe[0][B_DISP]);

    always_ff @(posedge clk) begin
      if (reset) begin
        icnt <= 8'd0;
        vcnt <= 8'd0;
        cd   <= 1'b1;
      end else begin
        if ((state == ST_LOCKED) && alt_runlengthviolation[n]) begin
          // A run-length violation forces an immediate carrier drop.
          icnt <= CD_HOLD_C;
          vcnt <= 8'd0;
        end else if (stage1_invalid) begin
          icnt <= (icnt == 8'hFF) ? icnt : icnt + 8'd1;
          vcnt <= 8'd0;
        end else begin
          vcnt <= (vcnt == 8'hFF) ? vcnt : vcnt + 8'd1;
          icnt <= 8'd0;
        end
        if (icnt >= CD_HOLD_C)         cd <= 1'b0;
        else if (vcnt >= CD_RECOVER_C) cd <= 1'b1;
      end
    end

    assign altpcs_carrierdetect[n] = cd;

    always_ff @(posedge clk) begin
      if (reset)                          loss_cnt <= 8'd0;
      else if (cnt_clr)                   loss_cnt <= loss ? 8'd1 : 8'd0;
      else if (loss && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
    end

    assign sync_loss_cnt[8*n +: 8] = loss_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) altpcs_all_locked <= 1'b0;
    else       altpcs_all_locked <= &lock_final;
  end

endmodule

// File: tb/tb_altera_tse_gxb_rxsync_multilane.sv
// Directed testbench for altera_tse_gxb_rxsync_multilane with two lanes,
// PIPE_DEPTH=2, SYNC_QUAL=4, CD_HOLD=8, CD_RECOVER=4.
module tb_altera_tse_gxb_rxsync_multilane;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] alt_dataout;
  logic [1:0]  alt_sync, alt_disperr, alt_ctrldetect, alt_errdetect;
  logic [1:0]  alt_rmfifodatadeleted, alt_rmfifodatainserted, alt_runlengthviolation;
  logic        cnt_clr;
  logic [15:0] altpcs_dataout;
  logic [1:0]  altpcs_sync, altpcs_disperr, altpcs_ctrldetect, altpcs_errdetect;
  logic [1:0]  altpcs_rmfifodatadeleted, altpcs_rmfifodatainserted, altpcs_carrierdetect;
  logic        altpcs_all_locked;
  logic [15:0] sync_loss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  altera_tse_gxb_rxsync_multilane #(
    .LANES(2), .PIPE_DEPTH(2), .SYNC_QUAL(4), .CD_HOLD(8), .CD_RECOVER(4)
  ) dut (
    .clk(clk), .reset(reset),
    .alt_dataout(alt_dataout), .alt_sync(alt_sync), .alt_disperr(alt_disperr),
    .alt_ctrldetect(alt_ctrldetect), .alt_errdetect(alt_errdetect),
    .alt_rmfifodatadeleted(alt_rmfifodatadeleted),
    .alt_rmfifodatainserted(alt_rmfifodatainserted),
    .alt_runlengthviolation(alt_runlengthviolation), .cnt_clr(cnt_clr),
    .altpcs_dataout(altpcs_dataout), .altpcs_sync(altpcs_sync),
    .altpcs_disperr(altpcs_disperr), .altpcs_ctrldetect(altpcs_ctrldetect),
    .altpcs_errdetect(altpcs_errdetect),
    .altpcs_rmfifodatadeleted(altpcs_rmfifodatadeleted),
    .altpcs_rmfifodatainserted(altpcs_rmfifodatainserted),
    .altpcs_carrierdetect(altpcs_carrierdetect),
    .altpcs_all_locked(altpcs_all_locked), .sync_loss_cnt(sync_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs set before tick are captured on its edge; outputs read 1 ns after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values();
    chk("rst_data",   32'(altpcs_dataout), 32'h0);
    chk("rst_sync",   32'(altpcs_sync), 32'h0);
    chk("rst_err",    32'(altpcs_errdetect), 32'h3);
    chk("rst_disp",   32'(altpcs_disperr), 32'h3);
    chk("rst_ctrl",   32'(altpcs_ctrldetect), 32'h0);
    chk("rst_rm",     32'({altpcs_rmfifodatadeleted, altpcs_rmfifodatainserted}), 32'h0);
    chk("rst_cd",     32'(altpcs_carrierdetect), 32'h3);
    chk("rst_allock", 32'(altpcs_all_locked), 32'h0);
    chk("rst_cnt",    32'(sync_loss_cnt), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cnt_clr = 1'b0;
    alt_dataout = 16'h0; alt_sync = 2'b00; alt_disperr = 2'b00;
    alt_ctrldetect = 2'b00; alt_errdetect = 2'b00;
    alt_rmfifodatadeleted = 2'b00; alt_rmfifodatainserted = 2'b00;
    alt_runlengthviolation = 2'b00;
    tick(); tick();
    chk_reset_values();
    reset = 1'b0;

    // Lane 0 qualifies and locks; lane 1 stays unsynced and squelched.
    alt_dataout = 16'hAA50; alt_sync = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k <= 4) begin
        chk("t1_sync0_pre", 32'(altpcs_sync[0]), 32'h0);
        chk("t1_data0_pre", 32'(altpcs_dataout[7:0]), 32'h0);
      end
      if (k == 5) begin
        chk("t1_sync0", 32'(altpcs_sync[0]), 32'h1);
        chk("t1_data0", 32'(altpcs_dataout[7:0]), 32'h50);
        chk("t1_err0",  32'(altpcs_errdetect[0]), 32'h0);
      end
      chk("t1_data1",  32'(altpcs_dataout[15:8]), 32'h0);
      chk("t1_err1",   32'(altpcs_errdetect[1]), 32'h1);
      chk("t1_allock", 32'(altpcs_all_locked), 32'h0);
      if (k == 8) chk("t1_cd1_hold", 32'(altpcs_carrierdetect[1]), 32'h1);
      if (k == 9) chk("t1_cd1_drop", 32'(altpcs_carrierdetect[1]), 32'h0);
      chk("t1_cd0", 32'(altpcs_carrierdetect[0]), 32'h1);
    end

    // Lane 1 locks too: all_locked follows one cycle after both syncs.
    alt_sync = 2'b11;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 4) chk("al_sync1_pre", 32'(altpcs_sync[1]), 32'h0);
      if (k == 5) begin
        chk("al_sync1",   32'(altpcs_sync[1]), 32'h1);
        chk("al_data1",   32'(altpcs_dataout[15:8]), 32'hAA);
        chk("al_allock0", 32'(altpcs_all_locked), 32'h0);
      end
      if (k == 6) chk("al_allock1", 32'(altpcs_all_locked), 32'h1);
      if (k == 8) chk("al_cd1_low", 32'(altpcs_carrierdetect[1]), 32'h0);
      if (k == 9) chk("al_cd1_up",  32'(altpcs_carrierdetect[1]), 32'h1);
    end

    // One loss on lane 1, then cnt_clr alone clears it.
    alt_sync[1] = 1'b0;
    tick();
    chk("t2_loss1", 32'(sync_loss_cnt[15:8]), 32'h1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t2_clr1", 32'(sync_loss_cnt[15:8]), 32'h0);
    chk("t2_cnt0", 32'(sync_loss_cnt[7:0]), 32'h0);

    // Lane 1 sync pattern 1,1,1,0 never reaches SYNC_QUAL.
    for (int p = 0; p < 24; p++) begin
      alt_sync[1] = ((p % 4) != 3);
      tick();
      chk("t2_sync1", 32'(altpcs_sync[1]), 32'h0);
      chk("t2_data1", 32'(altpcs_dataout[15:8]), 32'h0);
    end
    chk("t2_cnt1", 32'(sync_loss_cnt[15:8]), 32'h0);
    alt_sync[1] = 1'b0;

    // 300 single-cycle sync drops on locked lane 0: counter saturates.
    for (int i = 0; i < 300; i++) begin
      alt_sync[0] = 1'b0;
      tick();
      alt_sync[0] = 1'b1;
      for (int j = 0; j < 4; j++) tick();
      if (i == 0)   chk("t3_cnt1",  32'(sync_loss_cnt[7:0]), 32'h01);
      if (i == 253) chk("t3_cntFE", 32'(sync_loss_cnt[7:0]), 32'hFE);
      if (i == 254) chk("t3_cntFF", 32'(sync_loss_cnt[7:0]), 32'hFF);
    end
    chk("t3_sat", 32'(sync_loss_cnt[7:0]), 32'hFF);
    chk("t3_cd0", 32'(altpcs_carrierdetect[0]), 32'h1);
    cnt_clr = 1'b1; alt_sync[0] = 1'b0;
    tick();
    chk("t3_clr_loss", 32'(sync_loss_cnt[7:0]), 32'h01);
    cnt_clr = 1'b0; alt_sync[0] = 1'b1;
    for (int j = 0; j < 10; j++) tick();
    chk("t3_relock", 32'(altpcs_sync[0]), 32'h1);

    // Seven invalid stage-1 cycles do not drop carrier.
    for (int t = 1; t <= 16; t++) begin
      {alt_errdetect[0], alt_disperr[0]} = (t <= 7) ? 2'b11 : 2'b00;
      tick();
      chk("t4_cd_7", 32'(altpcs_carrierdetect[0]), 32'h1);
    end
    // Eight invalid cycles drop it; four valid cycles restore it.
    for (int t = 1; t <= 14; t++) begin
      {alt_errdetect[0], alt_disperr[0]} = (t <= 8) ? 2'b11 : 2'b00;
      tick();
      chk("t4_cd_8", 32'(altpcs_carrierdetect[0]), (t >= 10 && t <= 13) ? 32'h0 : 32'h1);
      if (t == 2) chk("t4_err_pass", 32'(altpcs_errdetect[0]), 32'h1);
    end

    // Single-cycle run-length violation while locked.
    for (int r = 0; r <= 6; r++) begin
      alt_runlengthviolation[0] = (r == 0);
      tick();
      chk("t5_cd", 32'(altpcs_carrierdetect[0]), (r >= 1 && r <= 4) ? 32'h0 : 32'h1);
    end
    alt_runlengthviolation[0] = 1'b0;

    // Mid-traffic reset, then re-qualification from LOST.
    reset = 1'b1;
    tick();
    chk_reset_values();
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t6_sync0", 32'(altpcs_sync[0]), (k == 5) ? 32'h1 : 32'h0);
      chk("t6_data0", 32'(altpcs_dataout[7:0]), (k == 5) ? 32'h50 : 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
